spi_master: RTL and testbench

//  FPGA-side SPI master; the initiator end of the link served by our spi_slave.

---
 rtl/spi_pkg.sv | 15 +
 rtl/sck_tick_gen.sv | 40 ++++
 rtl/spi_master.sv | 138 +++++++++++++
 tb/tb_spi_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and frame width
// Frame width is shared with spi_slave so both ends of the link agree.
package spi_pkg;

  localparam int SPI_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
  } spi_state_t;

endpackage

// File: rtl/sck_tick_gen.sv
// rtl/sck_tick_gen.sv - sck half-period divider
// Counts clk cycles while enabled and flags the last cycle of each sck phase.
module sck_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clear_i,
  output logic phase_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter wraps on the tick itself, so every phase starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_tick_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode 0 master, one full-duplex WIDTH-bit frame per start
// Frame: SETUP, then WIDTH x (HIGH, LOW), then a single DONE cycle.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             sdi,
  output logic             sck,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rxd_q, rxd_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sck_q, sck_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic             accept;
  logic             div_en;

  assign accept = start && !busy_q && (state_q == IDLE || state_q == DONE);
  assign div_en = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk         (clk),
    .rst_n       (reset),
    .en_i        (div_en),
    .clear_i     (accept),
    .phase_tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          tx_d    = tx_data;
          sdo_d   = tx_data[WIDTH-1];
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], sdi};
          state_d = HIGH;
        end
      end
      HIGH: begin
        // sdo only moves on the falling edge so the slave sees it stable at the rise.
        if (tick) begin
          sck_d   = 1'b0;
          state_d = LOW;
          if (bit_q != BIT_LAST) begin
            tx_d  = {tx_q[WIDTH-2:0], 1'b0};
            sdo_d = tx_q[WIDTH-2];
          end
        end
      end
      LOW: begin
        if (tick) begin
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BW'(1);
            sck_d   = 1'b1;
            rx_d    = {rx_q[WIDTH-2:0], sdi};
            state_d = HIGH;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rxd_d   = rx_q;
            sdo_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sck     = sck_q;
  assign sdo     = sdo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rxd_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master
// Stimulus pushes expected rx words, done cycles and sdo bits; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int W   = 10;
  localparam int DIV = 4;
  localparam int LAT = 84;

  typedef struct packed {
    logic [W-1:0] rx;
    int           at;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         sdi;
  logic         sck, sdo, busy, done;
  logic [W-1:0] rx_data;

  int           sdi_mode = 0;
  logic [W-1:0] slv_sh = '0;
  logic [W-1:0] slv_q = '0;
  logic         slv_load = 1'b0;
  logic         s_prev = 1'b0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   rises = 0;
  int   last_fall = 0;
  int   min_gap = 1000;
  logic m_prev = 1'b0;
  exp_t sb[$];
  logic bq[$];

  spi_master #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .tx_data(tx_data),
    .sdi    (sdi),
    .sck    (sck),
    .sdo    (sdo),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sdi = (sdi_mode == 0) ? 1'b1 : (sdi_mode == 1) ? sdo : slv_sh[W-1];

  // Mode 0 slave model: shifts out after sck falls, captures sdo after sck rises.
  always @(posedge clk) begin
    s_prev <= sck;
    if (slv_load) slv_sh <= 10'h0F0;
    else if (s_prev && !sck) slv_sh <= {slv_sh[W-2:0], 1'b0};
    if (!s_prev && sck) slv_q <= {slv_q[W-2:0], sdo};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rx_data", rx_data, e.rx);
        chk("done_cycle", cyc, e.at);
      end
    end
    if (sck && !m_prev) begin
      rises++;
      if (last_fall > 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      if (bq.size() > 0) chk("sdo_bit", sdo, bq.pop_front());
    end
    if (!sck && m_prev) last_fall = cyc;
    m_prev = sck;
  end

  task automatic push_bits(input logic [W-1:0] tx);
    for (int i = W - 1; i >= 0; i--) bq.push_back(tx[i]);
  endtask

  task automatic launch(input logic [W-1:0] tx, input logic [W-1:0] rx_exp, output int acc);
    @(negedge clk);
    tx_data = tx;
    start   = 1'b1;
    acc     = cyc + 1;
    sb.push_back('{rx: rx_exp, at: acc + LAT});
    push_bits(tx);
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~tx;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    chk("done_wait", done_cnt >= target, 1);
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 500 && cyc != c; i++) @(negedge clk);
    chk("cycle_reach", cyc, c);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a, r0, saved;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // sdi tied high
    sdi_mode = 0;
    launch(10'h2A5, 10'h3FF, a);
    wait_done(1, 200);
    repeat (3) @(negedge clk);

    // loopback
    sdi_mode = 1;
    r0 = rises;
    launch(10'h155, 10'h155, a);
    wait_done(2, 200);
    chk("sck_pulses", rises - r0, 10);
    repeat (3) @(negedge clk);

    // paired with slave model
    sdi_mode = 2;
    slv_load = 1'b1;
    @(negedge clk);
    slv_load = 1'b0;
    launch(10'h30C, 10'h0F0, a);
    wait_done(3, 200);
    repeat (2) @(negedge clk);
    chk("slave_q", slv_q, 10'h30C);

    // start pulses while busy are ignored
    sdi_mode = 1;
    launch(10'h1B3, 10'h1B3, a);
    wait_cyc(a + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(a + 49);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, 200);
    repeat (100) @(negedge clk);
    chk("single_done", done_cnt, 4);
    chk("idle_busy", busy, 0);

    // start held through done: back-to-back frames
    min_gap = 1000;
    @(negedge clk);
    tx_data = 10'h2C6;
    start   = 1'b1;
    a       = cyc + 1;
    sb.push_back('{rx: 10'h2C6, at: a + LAT});
    sb.push_back('{rx: 10'h139, at: a + LAT + 1 + LAT});
    push_bits(10'h2C6);
    wait_cyc(a + LAT);
    chk("b2b_done1", done, 1);
    tx_data = 10'h139;
    push_bits(10'h139);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    wait_done(6, 200);
    chk("min_sck_low", min_gap >= DIV, 1);
    repeat (3) @(negedge clk);

    // async reset mid-frame
    launch(10'h2F0, 10'h2F0, a);
    wait_cyc(a + 40);
    rst_n = 1'b0;
    #1;
    chk("abort_sck", sck, 0);
    chk("abort_sdo", sdo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx", rx_data, 0);
    sb.delete();
    bq.delete();
    saved = done_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt, saved);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    launch(10'h3C3, 10'h3C3, a);
    wait_done(saved + 1, 200);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
